// File: rtl/clk_en_gen.sv
// clk_en_gen: fractional clock-enable generator gated by a PLL lock-settle sequencer.
// Each channel runs a phase accumulator. The carry out of the wrapping add becomes
// a one-cycle strobe on en_o.
// Optional feature: define CLK_EN_GEN_LOSS_CNT_EN to add loss_cnt_o. It is a
// saturating count of lock losses seen while in RUN.
module clk_en_gen #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 locked_i,
    input  logic                 sync_i,
    input  logic [NCH*ACC_W-1:0] inc_i,
`ifdef CLK_EN_GEN_LOSS_CNT_EN
    output logic [7:0]           loss_cnt_o,
`endif
    output logic                 ready_o,
    output logic [NCH-1:0]       en_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

    typedef enum logic [1:0] {StWaitLock, StSettle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lk_meta_q, lk_q;
    logic [ACC_W-1:0]   acc_q [NCH];
    logic [ACC_W-1:0]   acc_d [NCH];
    logic [ACC_W:0]     sum;
    logic [NCH-1:0]     en_q, en_d;
    logic               ready_q, ready_d;
    logic               run_add;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            lk_meta_q <= locked_i;
            lk_q      <= lk_meta_q;
        end
    end

    // Lock-settle sequencer next state and settle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWaitLock: begin
                cnt_d = '0;
                if (lk_q) state_d = StSettle;
            end
            StSettle: begin
                if (!lk_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!lk_q) state_d = StWaitLock;
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase
    end

    // Only an uninterrupted RUN cycle advances phase; lock loss outranks sync
    assign run_add = (state_q == StRun) && lk_q && !sync_i;
    assign ready_d = (state_d == StRun);

    // Per-channel wrapping add; carry out becomes next cycle's strobe
    always_comb begin
        en_d = '0;
        sum  = '0;
        for (int k = 0; k < NCH; k++) begin
            acc_d[k] = '0;
            sum = {1'b0, acc_q[k]} + {1'b0, inc_i[k*ACC_W +: ACC_W]};
            if (run_add) begin
                acc_d[k] = sum[ACC_W-1:0];
                en_d[k]  = sum[ACC_W];
            end
        end
    end

    // State, counter, accumulators and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            acc_q   <= '{default: '0};
            en_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign en_o    = en_q;

`ifdef CLK_EN_GEN_LOSS_CNT_EN
    logic [7:0] loss_q;

    // Saturating count of RUN -> WAIT_LOCK transitions; settle drops are not counted
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            loss_q <= '0;
        end else if (state_q == StRun && state_d == StWaitLock && loss_q != 8'hff) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt_o = loss_q;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen (NCH=4, ACC_W=32, LOCK_CYCLES=16).
// A reference model pushes the expected outputs for every clock into a queue.
// A monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_clk_en_gen;

    localparam int unsigned NCH   = 4;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned LOCK  = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i = 1'b0;
    logic                 locked_i = 1'b0;
    logic                 sync_i = 1'b0;
    logic [NCH*ACC_W-1:0] inc_i = '0;
    logic                 ready_o;
    logic [NCH-1:0]       en_o;
    logic [7:0]           loss_cnt_o;

    clk_en_gen #(
        .NCH         (NCH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .locked_i   (locked_i),
        .sync_i     (sync_i),
        .inc_i      (inc_i),
`ifdef CLK_EN_GEN_LOSS_CNT_EN
        .loss_cnt_o (loss_cnt_o),
`endif
        .ready_o    (ready_o),
        .en_o       (en_o)
    );

`ifndef CLK_EN_GEN_LOSS_CNT_EN
    assign loss_cnt_o = 8'd0;
`endif

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic           ready;
        logic [NCH-1:0] en;
        logic [7:0]     loss;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Stimulus values held by the driver
    logic [31:0] inc_v [NCH];

    // Reference model: lock history, consecutive-locked run length, phases
    logic              hist1 = 1'b0, hist2 = 1'b0;
    int                hi_run = 0;
    longint unsigned   phase [NCH];
    int                m_loss = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs just driven
    task automatic model_edge();
        exp_t e;
        logic lk, run_pre;
        e.en = '0;
        if (!rst_n_i) begin
            hist1 = 1'b0; hist2 = 1'b0; hi_run = 0; m_loss = 0;
            for (int k = 0; k < NCH; k++) phase[k] = 0;
            e.ready = 1'b0;
        end else begin
            lk = hist2;
            run_pre = (hi_run > LOCK);
            // RUN needs lk seen high on LOCK+1 consecutive edges
            if (lk) hi_run = (hi_run > LOCK) ? LOCK + 1 : hi_run + 1;
            else    hi_run = 0;
            if (run_pre && !lk && m_loss < 255) m_loss++;
            for (int k = 0; k < NCH; k++) begin
                if (run_pre && lk && !sync_i) begin
                    phase[k] = phase[k] + longint'(inc_v[k]);
                    if (phase[k] >= 64'h1_0000_0000) begin
                        e.en[k] = 1'b1;
                        phase[k] = phase[k] - 64'h1_0000_0000;
                    end
                end else begin
                    phase[k] = 0;
                end
            end
            e.ready = (hi_run > LOCK);
            hist2 = hist1;
            hist1 = locked_i;
        end
        e.loss = 8'(m_loss);
        exp_q.push_back(e);
    endtask

    // One clock: drive on the falling edge, return 1 time unit after the rising edge
    task automatic step(input logic rst, input logic lck, input logic syn);
        @(negedge clk_i);
        rst_n_i  = rst;
        locked_i = lck;
        sync_i   = syn;
        for (int k = 0; k < NCH; k++) inc_i[k*ACC_W +: ACC_W] = inc_v[k];
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    // Steps with locked held high until ready_o rises, bounded
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 200) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
            if (ready_o === 1'b1) break;
        end
    endtask

    // Monitor: one expected entry per clock
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready_o", longint'(ready_o), longint'(e.ready));
                check("en_o", longint'(en_o), longint'(e.en));
`ifdef CLK_EN_GEN_LOSS_CNT_EN
                check("loss_cnt_o", longint'(loss_cnt_o), longint'(e.loss));
`endif
            end
        end
    end

    initial begin
        int n, cnt0, cnt1, cnt2, bad_gap, last1, mism;
        logic ready_seen;
        inc_v[0] = 32'h4000_0000;
        inc_v[1] = 32'h5555_5555;
        inc_v[2] = 32'h0000_0000;
        inc_v[3] = 32'h1234_5678;

        // Reset with locked high, then count edges until ready
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        wait_ready(n);
        check("ready_latency_after_reset", n, 19);

        // Strobe counts over RUN cycles 1..3000
        cnt0 = 0; cnt1 = 0; cnt2 = 0; bad_gap = 0; last1 = -1;
        for (int c = 1; c <= 3000; c++) begin
            step(1'b1, 1'b1, 1'b0);
            if (en_o[0]) cnt0++;
            if (en_o[2]) cnt2++;
            if (en_o[1]) begin
                cnt1++;
                if (last1 >= 0 && (c - last1 < 3 || c - last1 > 4)) bad_gap++;
                last1 = c;
            end
        end
        check("div4_strobes", cnt0, 750);
        check("frac_strobes_ge_999", longint'(cnt1 >= 999), 1);
        check("frac_strobes_le_1000", longint'(cnt1 <= 1000), 1);
        check("frac_gap_3_or_4", bad_gap, 0);
        check("inc0_zero_strobes", cnt2, 0);

        // Lock loss in RUN: outputs drop on the third edge
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("ready_two_after_drop", longint'(ready_o), 1);
        step(1'b1, 1'b0, 1'b0);
        check("ready_three_after_drop", longint'(ready_o), 0);
        check("en_three_after_drop", longint'(en_o), 0);
`ifdef CLK_EN_GEN_LOSS_CNT_EN
        check("loss_after_drop", longint'(loss_cnt_o), 1);
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);

        // Re-lock, glitch locked mid-settle, settle restarts in full
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        ready_seen = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (ready_o) ready_seen = 1'b1;
        end
        check("ready_low_after_glitch", longint'(ready_seen), 0);
        step(1'b1, 1'b1, 1'b0);
        check("ready_after_glitch_settle", longint'(ready_o), 1);
`ifdef CLK_EN_GEN_LOSS_CNT_EN
        check("loss_settle_drop_uncounted", longint'(loss_cnt_o), 1);
`endif

        // Run channels 0 and 3 out of phase, then sync them
        for (int i = 0; i < 37; i++) step(1'b1, 1'b1, 1'b0);
        inc_v[3] = 32'h4000_0000;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("en_after_sync", longint'(en_o), 0);
        mism = 0; cnt0 = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (en_o[0] != en_o[3]) mism++;
            if (en_o[0]) cnt0++;
        end
        check("sync_ch0_ch3_coincident", mism, 0);
        check("sync_ch0_strobes", cnt0, 50);

        // Randomised: rate changes, sync pulses, lock glitches, rare resets
        begin
            logic lck;
            int   drop;
            drop = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(99) == 0) begin
                    case ($urandom_range(4))
                        0: inc_v[$urandom_range(NCH-1)] = 32'h0;
                        1: inc_v[$urandom_range(NCH-1)] = 32'hffff_ffff;
                        2: inc_v[$urandom_range(NCH-1)] = 32'h8000_0000;
                        default: inc_v[$urandom_range(NCH-1)] = $urandom;
                    endcase
                end
                if (drop == 0 && $urandom_range(299) == 0) drop = $urandom_range(5, 1);
                lck = (drop == 0);
                if (drop > 0) drop--;
                step(($urandom_range(1999) != 0), lck, ($urandom_range(49) == 0));
            end
        end

        // Drain the scoreboard, bounded
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge clk_i);
            n++;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Parametrised fractional clock-enable generator that follows the board PLL block on the fabric clock.
- Derives NCH independent strobe rates from one clock with a phase accumulator per channel, so new rates need no extra PLL/BUFG.
- Gates all strobes behind a lock-settle sequencer driven by the PLL LOCKED output.
- Consumers (video pixel enable, UART baud, audio sample tick) run on clk_i and qualify logic with en_o[k].

Parameters:
- NCH, 4, number of strobe channels (1..8).
- ACC_W, 32, accumulator width per channel (8..32).
- LOCK_CYCLES, 1024, cycles locked must stay high before strobes run (>=2).

Ports:
- clk_i  input  1  fabric clock (PLL output, BUFG-driven).
- rst_n_i  input  1  synchronous active-low reset.
- locked_i  input  1  PLL LOCKED, asynchronous to clk_i.
- sync_i  input  1  pulse; realigns all channel phases to zero.
- inc_i  input  NCH*ACC_W  per-channel phase increment; channel k at bits [k*ACC_W +: ACC_W].
- ready_o  output  1  high while in RUN.
- en_o  output  NCH  single-cycle strobe per channel.

Behaviour:
- Clock/reset: one clock, clk_i. Reset is synchronous and active-low on rst_n_i, sampled on the rising edge of clk_i.
- Reset values: state=WAIT_LOCK, settle counter=0, all accumulators=0, 2-flop locked synchroniser=0, ready_o=0, en_o=0.
- locked_i passes through a 2-flop synchroniser to give lk. All FSM decisions use lk.
- WAIT_LOCK: counter held at 0. When lk=1, go to SETTLE.
- SETTLE: counter increments each cycle. If lk=0, go to WAIT_LOCK and clear the counter. When counter == LOCK_CYCLES-1 with lk=1, go to RUN.
- RUN: ready_o=1 (registered, high from the first RUN cycle). If lk=0, go to WAIT_LOCK. On that edge, accumulators clear and ready_o/en_o go 0.
- Accumulators change only in RUN; in other states they hold 0.
- Per channel in RUN, each cycle: {carry, acc} = acc + inc_k, computed at ACC_W+1 bits. The accumulator wraps mod 2^ACC_W. en_o[k] <= carry (registered, 1-cycle latency after the wrapping add).
- Mean strobe rate = f_clk * inc_k / 2^ACC_W. Strobe spacing is floor or ceil of 2^ACC_W / inc_k cycles.
- inc_k = 0: never strobes. inc_k >= 2^(ACC_W-1) is legal; above that, strobes can be adjacent. Maximum inc (all ones) strobes on all but 1 in 2^ACC_W cycles.
- inc_i is sampled every cycle; a change takes effect on the next add with no phase reset.
- sync_i=1 in RUN: all accumulators load 0 (no add that cycle) and en_o <= 0. Channels restart in phase. sync_i is ignored outside RUN.
- Simultaneous lk drop and sync_i: the lock-loss path wins (same cleared result, state goes to WAIT_LOCK).
- rst_n_i low mid-RUN: next edge returns to reset values. The synchroniser is also cleared, so a full LOCK_CYCLES settle is required again.

Optional Feature:
- Macro: CLK_EN_GEN_LOSS_CNT_EN.
- Defined: adds output loss_cnt_o [7:0], reset 0. It increments on every RUN->WAIT_LOCK transition and saturates at 255; only rst_n_i clears it. SETTLE->WAIT_LOCK drops are not counted.
- Undefined: port and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset then settle: rst_n_i low 5 cycles, locked_i=1 from cycle 0, LOCK_CYCLES=16 -> ready_o rises exactly 2 (sync) + 1 + 16 cycles after reset release; en_o=0 throughout.
- Divide by 4: ACC_W=32, inc0=0x4000_0000 -> en_o[0] high in RUN cycles 4, 8, 12, ... (RUN cycle 0 = first ready_o=1); 250 strobes in 1000 cycles.
- Fractional rate: inc1=0x5555_5555 -> strobe spacing only 3 or 4 cycles; 3000 cycles give 999..1000 strobes. inc2=0 -> zero strobes.
- Mid-settle glitch: locked_i low for 1 cycle at settle count 10 -> return to WAIT_LOCK, full 16-cycle settle restarts, ready_o stays 0.
- Lock loss in RUN plus sync_i: drop locked_i -> ready_o and en_o 0 three cycles later, and loss_cnt_o=1 (macro on). Re-lock, then pulse sync_i with inc0=inc3=0x4000_0000 at different phases -> en_o[0] and en_o[3] coincident from then on.
